// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states, control-bundle
// widths, and the output bundle with its reset and per-state values.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ABORT    = 2'd2
   } state_e;

   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 5;

   // M group ordering is {Branch, MemRead, MemWrite}
   localparam int M_MEMREAD_IDX = 1;

   typedef struct packed {
      logic pc_write;
      logic if_write;
      logic if_flush;
      logic ctr_flush;
      logic mem_stall;
   } ctrl_t;

   localparam ctrl_t CTRL_RST    = '{pc_write: 1'b0, if_write: 1'b0, if_flush: 1'b1, ctr_flush: 1'b1, mem_stall: 1'b0};
   localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_write: 1'b1, if_flush: 1'b0, ctr_flush: 1'b0, mem_stall: 1'b0};
   localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_write: 1'b0, if_flush: 1'b0, ctr_flush: 1'b0, mem_stall: 1'b1};
   localparam ctrl_t CTRL_LU     = '{pc_write: 1'b0, if_write: 1'b0, if_flush: 1'b0, ctr_flush: 1'b1, mem_stall: 1'b0};
   localparam ctrl_t CTRL_ABORT  = '{pc_write: 1'b1, if_write: 1'b0, if_flush: 1'b1, ctr_flush: 1'b1, mem_stall: 1'b0};

   // Normal-flow decision: a load-use bubble beats a redirect flush
   function automatic ctrl_t run_ctrl(input logic lu_hit, input logic redirect);
      ctrl_t c;
      c = CTRL_RUN;
      if (lu_hit) begin
         c = CTRL_LU;
      end else if (redirect) begin
         c.if_flush = 1'b1;
      end else begin
         c = CTRL_RUN;
      end
      return c;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in EX and the sources of the ID instruction.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   output logic       hit
);

   // $0 is hard-wired zero, so a load targeting it never hazards
   assign hit = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, redirect flush, memory-wait freeze
// with watchdog abort. Optional perf counters under PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic       id_redirect,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       if_write,
   output logic       if_flush,
   output logic       ctr_flush,
   output logic       mem_stall,
   output logic       mem_err
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0] perf_lu_stalls,
   output logic [31:0] perf_mem_stalls,
   output logic [31:0] perf_flushes
`endif
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_err_q, mem_err_d;
   logic             lu_hit;
   ctrl_t            ctl;

   load_use_detect u_lud (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .ex_memread (ex_memread),
      .ex_rt      (ex_rt),
      .hit        (lu_hit)
   );

   always_comb begin
      ctl       = CTRL_RUN;
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_err_d = mem_err_q;
      if (rst) begin
         ctl       = CTRL_RST;
         state_d   = RUN;
         cnt_d     = '0;
         mem_err_d = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  ctl     = CTRL_FREEZE;
                  state_d = MEM_WAIT;
                  cnt_d   = CNT_W'(1);
               end else begin
                  ctl = run_ctrl(lu_hit, id_redirect);
               end
            end
            MEM_WAIT: begin
               // Ready releases the freeze in the same cycle
               if (mem_ready) begin
                  ctl     = run_ctrl(lu_hit, id_redirect);
                  state_d = RUN;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                  ctl       = CTRL_FREEZE;
                  state_d   = ABORT;
                  cnt_d     = '0;
                  mem_err_d = 1'b1;
               end else begin
                  ctl   = CTRL_FREEZE;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ABORT: begin
               ctl     = CTRL_ABORT;
               state_d = RUN;
               cnt_d   = '0;
            end
            default: begin
               ctl     = CTRL_RST;
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
   end

   assign pc_write  = ctl.pc_write;
   assign if_write  = ctl.if_write;
   assign if_flush  = ctl.if_flush;
   assign ctr_flush = ctl.ctr_flush;
   assign mem_stall = ctl.mem_stall;
   assign mem_err   = mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] perf_lu_q, perf_lu_d;
   logic [31:0] perf_mem_q, perf_mem_d;
   logic [31:0] perf_fl_q, perf_fl_d;

   // A load-use bubble is the only response with ctr_flush but no if_flush
   always_comb begin
      perf_lu_d  = perf_lu_q;
      perf_mem_d = perf_mem_q;
      perf_fl_d  = perf_fl_q;
      if (rst) begin
         perf_lu_d  = 32'd0;
         perf_mem_d = 32'd0;
         perf_fl_d  = 32'd0;
      end else begin
         if (ctl.ctr_flush && !ctl.if_flush) perf_lu_d = sat_inc32(perf_lu_q);
         else perf_lu_d = perf_lu_q;
         if (ctl.mem_stall) perf_mem_d = sat_inc32(perf_mem_q);
         else perf_mem_d = perf_mem_q;
         if (ctl.if_flush) perf_fl_d = sat_inc32(perf_fl_q);
         else perf_fl_d = perf_fl_q;
      end
   end

   always_ff @(posedge clk) begin
      perf_lu_q  <= perf_lu_d;
      perf_mem_q <= perf_mem_d;
      perf_fl_q  <= perf_fl_d;
   end

   assign perf_lu_stalls  = perf_lu_q;
   assign perf_mem_stalls = perf_mem_q;
   assign perf_flushes    = perf_fl_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4): RUN-state vector table plus
// hand-written memory-wait, timeout and reset sequences.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_memread, id_redirect, mem_req, mem_ready;
   logic       pc_write, if_write, if_flush, ctr_flush, mem_stall, mem_err;
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] perf_lu_stalls, perf_mem_stalls, perf_flushes;
`endif

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_memread  (ex_memread),
      .ex_rt       (ex_rt),
      .id_redirect (id_redirect),
      .mem_req     (mem_req),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write),
      .if_write    (if_write),
      .if_flush    (if_flush),
      .ctr_flush   (ctr_flush),
      .mem_stall   (mem_stall),
      .mem_err     (mem_err)
`ifdef PIPE_HAZARD_PERF_EN
      ,
      .perf_lu_stalls  (perf_lu_stalls),
      .perf_mem_stalls (perf_mem_stalls),
      .perf_flushes    (perf_flushes)
`endif
   );

   always #5 clk = ~clk;

   // Expected encoding: {pc_write, if_write, if_flush, ctr_flush, mem_stall, mem_err}
   localparam logic [5:0] E_RUN = 6'b110000;
   localparam logic [5:0] E_LU  = 6'b000100;
   localparam logic [5:0] E_RDR = 6'b111000;
   localparam logic [5:0] E_FRZ = 6'b000010;
   localparam logic [5:0] E_RST = 6'b001100;

   typedef struct {
      string      name;
      logic [4:0] rs, rt, xrt;
      logic       uses_rt, memread, redirect, req, ready;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [5:0] outs();
      return {pc_write, if_write, if_flush, ctr_flush, mem_stall, mem_err};
   endfunction

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] xrt,
                        input logic uses_rt, input logic memread, input logic redirect,
                        input logic req, input logic ready);
      id_rs = rs; id_rt = rt; ex_rt = xrt; id_uses_rt = uses_rt;
      ex_memread = memread; id_redirect = redirect; mem_req = req; mem_ready = ready;
   endtask

   // Sample at negedge with current inputs, then advance to just after the next posedge
   task automatic chk(input string name, input logic [5:0] exp);
      @(negedge clk);
      checks++;
      if (outs() !== exp) begin
         errors++;
         $display("FAIL %s got %b want %b", name, outs(), exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{"idle",           5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN};
      vecs[1]  = '{"lu_rs",          5'd5, 5'd2, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_LU};
      vecs[2]  = '{"lu_after",       5'd5, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN};
      vecs[3]  = '{"lu_r0",          5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
      vecs[4]  = '{"rt_unused",      5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
      vecs[5]  = '{"rt_used",        5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_LU};
      vecs[6]  = '{"redirect",       5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_RDR};
      vecs[7]  = '{"redirect_lu",    5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_LU};
      vecs[8]  = '{"mem_1cyc",       5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN};
      vecs[9]  = '{"mem_1cyc_lu",    5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, E_LU};
      vecs[10] = '{"nomatch",        5'd8, 5'd6, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN};
      vecs[11] = '{"r0_rt_used",     5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_RDR};

      rst = 1'b1;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset0", E_RST);
      drive(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("reset1_inputs_ignored", E_RST);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].rs, vecs[i].rt, vecs[i].xrt, vecs[i].uses_rt, vecs[i].memread,
               vecs[i].redirect, vecs[i].req, vecs[i].ready);
         chk(vecs[i].name, vecs[i].exp);
      end

      // Memory wait of 3 stalled cycles, redirect and load-use ignored while frozen
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("mw_enter", E_FRZ);
      drive(5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("mw_ignore_hazards", E_FRZ);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("mw_wait2", E_FRZ);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("mw_release", E_RUN);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("mw_back_run", E_RUN);

      // Release cycle evaluates hazards: redirect flushes there
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("mw2_enter", E_FRZ);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      chk("mw2_release_redirect", E_RDR);

      // Timeout: entry + counter 1..4 = 5 frozen cycles, then ABORT
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) chk($sformatf("to_freeze%0d", i), E_FRZ);
      chk("to_abort", 6'b101101);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("to_after_sticky", 6'b110001);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("to_redirect_sticky", 6'b111001);

      // Reset in the middle of a memory wait clears state, counter and error
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("rmw_enter", 6'b000011);
      chk("rmw_wait", 6'b000011);
      rst = 1'b1;
      chk("rmw_rst_outputs", 6'b001101);
      rst = 1'b0;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rmw_run_after_rst", E_RUN);

      // Fresh watchdog count: exactly 5 frozen cycles before ABORT, bounded wait
      begin
         int n;
         logic seen;
         n = 0;
         seen = 1'b0;
         drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_stall) n++;
            else seen = 1'b1;
            @(posedge clk);
            #1;
         end
         checks++;
         if (!seen || n != 5) begin
            errors++;
            $display("FAIL wd_count got %0d frozen cycles (abort seen %0b) want 5", n, seen);
         end
      end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("wd_after_abort", 6'b110001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
